// File: rtl/bht_branch_predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bht_branch_predictor_pkg
// Description : Shared core constants: opcode classes and 2-bit counter codes.
// Revision    : 1.0 - initial release
// ============================================================================
package bht_branch_predictor_pkg;

   // Opcode class lives in op[4:2]; shared with the branch detector and decoder
   localparam logic [2:0] OP_CLS_BR = 3'b011;
   localparam logic [2:0] OP_CLS_J  = 3'b001;

   // 2-bit saturating counter states; bit 1 is the taken prediction
   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_e;

   typedef enum logic [1:0] {
      CLS_OTHER = 2'b00,
      CLS_BR    = 2'b01,
      CLS_J     = 2'b10
   } op_cls_e;

   function automatic op_cls_e classify(input logic [4:0] op);
      op_cls_e cls;
      cls = CLS_OTHER;
      if (op[4:2] == OP_CLS_BR) cls = CLS_BR;
      else if (op[4:2] == OP_CLS_J) cls = CLS_J;
      return cls;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bht_branch_predictor_if.sv
`default_nettype none
// ============================================================================
// Module      : bht_branch_predictor_if
// Description : Fetch-side predict and execute-side resolve signal bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface bht_branch_predictor_if #(
   parameter int CNT_W = 16
);
   logic             if_valid;
   logic [15:0]      if_pc;
   logic [4:0]       if_op;
   logic             pred_taken;
   logic             res_valid;
   logic [15:0]      res_pc;
   logic [4:0]       res_op;
   logic             res_taken;
   logic             res_pred;
   logic             mispredict;
   logic [CNT_W-1:0] branch_cnt;
   logic [CNT_W-1:0] mispred_cnt;

   // Pipeline side: drives fetch/resolve info, receives predictions and stats
   modport master (
      output if_valid, if_pc, if_op, res_valid, res_pc, res_op, res_taken, res_pred,
      input  pred_taken, mispredict, branch_cnt, mispred_cnt
   );

   // Predictor side
   modport slave (
      input  if_valid, if_pc, if_op, res_valid, res_pc, res_op, res_taken, res_pred,
      output pred_taken, mispredict, branch_cnt, mispred_cnt
   );
endinterface
`default_nettype wire

// File: rtl/bht_branch_predictor_sat_counter2.sv
`default_nettype none
// ============================================================================
// Module      : bht_branch_predictor_sat_counter2
// Description : sat_counter2 - 2-bit up/down saturating counter, resets to
//               weak not-taken.
// Revision    : 1.0 - initial release
// ============================================================================
module bht_branch_predictor_sat_counter2
   import bht_branch_predictor_pkg::*;
(
   input  wire logic       clk,
   input  wire logic       rst,
   input  wire logic       en,
   input  wire logic       inc,
   input  wire logic       dec,
   output logic [1:0]      cnt
);

   // Step towards strong taken on inc, strong not-taken on dec, hold at the ends
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= WNT;
      end else if (en) begin
         if (inc && (cnt != ST))
            cnt <= cnt + 2'd1;
         else if (dec && (cnt != SNT))
            cnt <= cnt - 2'd1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/bht_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : bht_branch_predictor
// Description : 2-bit saturating-counter BHT with combinational fetch-time
//               prediction, resolve-time update, mispredict flag and
//               saturating performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module bht_branch_predictor
   import bht_branch_predictor_pkg::*;
#(
   parameter int IDX_BITS = 4,
   parameter int CNT_W    = 16
)(
   input  wire logic              clk,
   input  wire logic              rst,
   bht_branch_predictor_if.slave  bus
);

   localparam int ENTRIES = 1 << IDX_BITS;

   logic [1:0]          ctr_q [ENTRIES];
   logic [IDX_BITS-1:0] rd_idx;
   logic [IDX_BITS-1:0] wr_idx;
   logic                res_is_br;
   logic                mispredict;
   logic [CNT_W-1:0]    branch_cnt;
   logic [CNT_W-1:0]    mispred_cnt;
   logic                unused_pc_bits;

   // Halfword-aligned PCs: bit 0 never selects an entry
   assign rd_idx         = bus.if_pc[IDX_BITS:1];
   assign wr_idx         = bus.res_pc[IDX_BITS:1];
   assign unused_pc_bits = ^{bus.if_pc[15:IDX_BITS+1], bus.if_pc[0],
                             bus.res_pc[15:IDX_BITS+1], bus.res_pc[0]};

   assign res_is_br  = bus.res_valid && (classify(bus.res_op) == CLS_BR);
   assign mispredict = bus.res_valid && (bus.res_taken != bus.res_pred);

   // One counter per entry; only the resolving conditional branch's entry moves
   generate
      for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
         localparam logic [IDX_BITS-1:0] ENTRY_IDX = IDX_BITS'(g);
         bht_branch_predictor_sat_counter2 u_ctr (
            .clk (clk),
            .rst (rst),
            .en  (res_is_br && (wr_idx == ENTRY_IDX)),
            .inc (bus.res_taken),
            .dec (!bus.res_taken),
            .cnt (ctr_q[g])
         );
      end
   endgenerate

   // Prediction reads the registered table, so a same-cycle update is not seen
   always_comb begin
      bus.pred_taken = 1'b0;
      if (bus.if_valid) begin
         case (classify(bus.if_op))
            CLS_J:   bus.pred_taken = 1'b1;
            CLS_BR:  bus.pred_taken = ctr_q[rd_idx][1];
            default: bus.pred_taken = 1'b0;
         endcase
      end
   end

   // Statistics counters stick at all-ones instead of wrapping
   always_ff @(posedge clk) begin
      if (rst) begin
         branch_cnt  <= '0;
         mispred_cnt <= '0;
      end else begin
         if (res_is_br && (branch_cnt != '1))
            branch_cnt <= branch_cnt + CNT_W'(1);
         if (mispredict && (mispred_cnt != '1))
            mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
   end

   assign bus.mispredict  = mispredict;
   assign bus.branch_cnt  = branch_cnt;
   assign bus.mispred_cnt = mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bht_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_bht_branch_predictor
// Description : Directed bench for bht_branch_predictor with a reference
//               table model feeding an expectation queue. A second instance
//               with 4-bit statistics shares the stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bht_branch_predictor;

   localparam logic [4:0] OP_BEQZ = 5'b01100;
   localparam logic [4:0] OP_BNEZ = 5'b01101;
   localparam logic [4:0] OP_J    = 5'b00100;
   localparam logic [4:0] OP_ADD  = 5'b00000;

   typedef struct {
      string tag;
      logic  pred;
      logic  mis;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   bht_branch_predictor_if #(.CNT_W(16)) bus  ();
   bht_branch_predictor_if #(.CNT_W(4))  bus4 ();

   bht_branch_predictor #(.IDX_BITS(4), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   bht_branch_predictor #(.IDX_BITS(4), .CNT_W(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4.slave)
   );

   assign bus4.if_valid  = bus.if_valid;
   assign bus4.if_pc     = bus.if_pc;
   assign bus4.if_op     = bus.if_op;
   assign bus4.res_valid = bus.res_valid;
   assign bus4.res_pc    = bus.res_pc;
   assign bus4.res_op    = bus.res_op;
   assign bus4.res_taken = bus.res_taken;
   assign bus4.res_pred  = bus.res_pred;

   always #5 clk = ~clk;

   exp_t       sb [$];
   logic [1:0] mtab [16];
   int         mbr;
   int         mmis;
   int         total;
   int         bad;

   function automatic int sat(input int v, input int maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   // One clock of stimulus: drive, queue the expectation, check at negedge, update model
   task automatic cycle(input logic iv, input logic [15:0] ipc, input logic [4:0] iop,
                        input logic rv, input logic [15:0] rpc, input logic [4:0] rop,
                        input logic rt, input logic rp, input string tag);
      exp_t e;
      exp_t got;
      logic [3:0] ri;
      bus.if_valid  = iv;
      bus.if_pc     = ipc;
      bus.if_op     = iop;
      bus.res_valid = rv;
      bus.res_pc    = rpc;
      bus.res_op    = rop;
      bus.res_taken = rt;
      bus.res_pred  = rp;
      e.tag  = tag;
      e.pred = 1'b0;
      if (iv) begin
         if (iop[4:2] == 3'b001)      e.pred = 1'b1;
         else if (iop[4:2] == 3'b011) e.pred = mtab[ipc[4:1]][1];
      end
      e.mis = rv && (rt != rp);
      sb.push_back(e);
      @(negedge clk);
      got = sb.pop_front();
      total++;
      assert (bus.pred_taken === got.pred) else begin
         bad++;
         $error("FAIL %s pred_taken got=%0b exp=%0b", got.tag, bus.pred_taken, got.pred);
      end
      total++;
      assert (bus.mispredict === got.mis) else begin
         bad++;
         $error("FAIL %s mispredict got=%0b exp=%0b", got.tag, bus.mispredict, got.mis);
      end
      total++;
      assert (bus4.pred_taken === got.pred) else begin
         bad++;
         $error("FAIL %s pred_taken(cnt4) got=%0b exp=%0b", got.tag, bus4.pred_taken, got.pred);
      end
      total++;
      assert (bus4.mispredict === got.mis) else begin
         bad++;
         $error("FAIL %s mispredict(cnt4) got=%0b exp=%0b", got.tag, bus4.mispredict, got.mis);
      end
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 16; i++) mtab[i] = 2'b01;
         mbr  = 0;
         mmis = 0;
      end else if (rv) begin
         ri = rpc[4:1];
         if (rop[4:2] == 3'b011) begin
            mbr++;
            if (rt && (mtab[ri] != 2'b11))       mtab[ri] = mtab[ri] + 2'd1;
            else if (!rt && (mtab[ri] != 2'b00)) mtab[ri] = mtab[ri] - 2'd1;
         end
         if (rt != rp) mmis++;
      end
      #1;
   endtask

   task automatic fetch(input logic [15:0] pc, input logic [4:0] op, input string tag);
      cycle(1'b1, pc, op, 1'b0, 16'h0, OP_ADD, 1'b0, 1'b0, tag);
   endtask

   task automatic resolve(input logic [15:0] pc, input logic [4:0] op,
                          input logic t, input logic p, input string tag);
      cycle(1'b0, 16'h0, OP_ADD, 1'b1, pc, op, t, p, tag);
   endtask

   task automatic chk_cnt(input string tag);
      @(negedge clk);
      total++;
      assert (bus.branch_cnt === 16'(sat(mbr, 65535))) else begin
         bad++;
         $error("FAIL %s branch_cnt got=%0d exp=%0d", tag, bus.branch_cnt, sat(mbr, 65535));
      end
      total++;
      assert (bus.mispred_cnt === 16'(sat(mmis, 65535))) else begin
         bad++;
         $error("FAIL %s mispred_cnt got=%0d exp=%0d", tag, bus.mispred_cnt, sat(mmis, 65535));
      end
      total++;
      assert (bus4.branch_cnt === 4'(sat(mbr, 15))) else begin
         bad++;
         $error("FAIL %s branch_cnt(cnt4) got=%0d exp=%0d", tag, bus4.branch_cnt, sat(mbr, 15));
      end
      total++;
      assert (bus4.mispred_cnt === 4'(sat(mmis, 15))) else begin
         bad++;
         $error("FAIL %s mispred_cnt(cnt4) got=%0d exp=%0d", tag, bus4.mispred_cnt, sat(mmis, 15));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      mbr   = 0;
      mmis  = 0;
      for (int i = 0; i < 16; i++) mtab[i] = 2'b01;

      // Reset, then first fetch of a BEQZ at entry 8
      rst = 1'b1;
      cycle(1'b0, 16'h0, OP_ADD, 1'b0, 16'h0, OP_ADD, 1'b0, 1'b0, "rst0");
      cycle(1'b0, 16'h0, OP_ADD, 1'b0, 16'h0, OP_ADD, 1'b0, 1'b0, "rst1");
      rst = 1'b0;
      fetch(16'h0010, OP_BEQZ, "first_fetch");
      chk_cnt("after_reset");
      total++;
      assert (bus.branch_cnt === 16'd0 && bus.mispred_cnt === 16'd0) else begin
         bad++;
         $error("FAIL reset_cnts got=%0d/%0d exp=0/0", bus.branch_cnt, bus.mispred_cnt);
      end

      // Two taken resolves predicted not-taken: 01 -> 10 -> 11
      resolve(16'h0010, OP_BEQZ, 1'b1, 1'b0, "train_t1");
      resolve(16'h0010, OP_BEQZ, 1'b1, 1'b0, "train_t2");
      fetch(16'h0010, OP_BEQZ, "trained_fetch");
      chk_cnt("after_train");
      total++;
      assert (bus.branch_cnt === 16'd2 && bus.mispred_cnt === 16'd2) else begin
         bad++;
         $error("FAIL train_cnts got=%0d/%0d exp=2/2", bus.branch_cnt, bus.mispred_cnt);
      end

      // Alias 0x0030 onto entry 8 and drive it to strong not-taken
      fetch(16'h0011, OP_BNEZ, "pc_bit0_ignored");
      for (int i = 0; i < 3; i++) resolve(16'h0030, OP_BNEZ, 1'b0, 1'b1, "alias_nt");
      fetch(16'h0010, OP_BEQZ, "alias_fetch");
      resolve(16'h0030, OP_BNEZ, 1'b1, 1'b0, "alias_t");
      fetch(16'h0010, OP_BEQZ, "alias_weak");

      // Saturate at strong taken, then walk back down
      for (int i = 0; i < 7; i++) resolve(16'h0010, OP_BEQZ, 1'b1, 1'b1, "sat_up");
      fetch(16'h0010, OP_BEQZ, "sat_fetch");
      resolve(16'h0010, OP_BEQZ, 1'b0, 1'b1, "down1");
      fetch(16'h0010, OP_BEQZ, "down1_fetch");
      resolve(16'h0010, OP_BEQZ, 1'b0, 1'b1, "down2");
      fetch(16'h0010, OP_BEQZ, "down2_fetch");
      chk_cnt("after_sat");

      // Same-cycle fetch and update of entry 8 (01 -> 10): no bypass
      cycle(1'b1, 16'h0010, OP_BEQZ, 1'b1, 16'h0010, OP_BEQZ, 1'b1, 1'b0, "simul");
      fetch(16'h0010, OP_BEQZ, "simul_next");

      // Jumps and non-branches: predicted taken, never touch table or branch_cnt
      fetch(16'h0020, OP_J, "jump_fetch");
      resolve(16'h0020, OP_J, 1'b1, 1'b1, "jump_res");
      resolve(16'h0010, OP_J, 1'b0, 1'b0, "jump_nt_res");
      resolve(16'h0010, OP_ADD, 1'b0, 1'b1, "nonbr_badpred");
      fetch(16'h0010, OP_BEQZ, "after_jump");
      fetch(16'h0010, OP_ADD, "nonbr_fetch");
      cycle(1'b0, 16'h0010, OP_J, 1'b0, 16'h0010, OP_BEQZ, 1'b1, 1'b0, "invalid_slots");
      chk_cnt("after_jump");

      // Reset coincident with a taken update on a trained entry
      rst = 1'b1;
      cycle(1'b1, 16'h0010, OP_BEQZ, 1'b1, 16'h0010, OP_BEQZ, 1'b1, 1'b0, "rst_update");
      rst = 1'b0;
      fetch(16'h0010, OP_BEQZ, "post_rst_fetch");
      chk_cnt("post_rst");
      resolve(16'h0010, OP_BEQZ, 1'b1, 1'b1, "post_rst_t");
      fetch(16'h0010, OP_BEQZ, "post_rst_weak");

      // Saturate the statistics: 16-bit mispredicts and the 4-bit instance
      for (int i = 0; i < 65540; i++) begin
         if (i < 40)
            resolve(16'(i * 2), OP_BEQZ, 1'b1, 1'b0, "stat_br");
         else
            resolve(16'h0000, OP_ADD, 1'b1, 1'b0, "stat_mis");
      end
      chk_cnt("stat_sat");
      total++;
      assert (bus.mispred_cnt === 16'hFFFF && bus4.branch_cnt === 4'hF) else begin
         bad++;
         $error("FAIL stat_allones got=%h/%h exp=ffff/f", bus.mispred_cnt, bus4.branch_cnt);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bht_branch_predictor.md
Name: bht_branch_predictor

Overview:
- Fetch-side 2-bit saturating-counter branch history table (BHT) for the pipelined 16-bit core.
- Predicts each fetched branch at IF.
- Consumes the resolved outcome from the execute-stage branch detector, updates the table and flags mispredicts so hazard logic can flush.
- Keeps saturating branch and mispredict counters for performance debug.

Parameters:
- IDX_BITS, 4, log2 of table entries (16); index = pc[IDX_BITS:1].
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- if_valid  in  1  fetch slot holds a real instruction
- if_pc  in  16  PC of fetched instruction
- if_op  in  5  opcode bits [15:11] of fetched instruction
- pred_taken  out  1  prediction for fetched instruction (combinational)
- res_valid  in  1  an instruction is resolving this cycle (not stalled, not squashed)
- res_pc  in  16  PC of resolving instruction
- res_op  in  5  opcode of resolving instruction
- res_taken  in  1  actual outcome from the branch detector
- res_pred  in  1  prediction carried down the pipe with this instruction
- mispredict  out  1  resolved outcome differs from prediction (combinational)
- branch_cnt  out  CNT_W  resolved conditional branches, saturating
- mispred_cnt  out  CNT_W  mispredicts, saturating

Behaviour:
- Opcode classes:
  - Conditional branch: op[4:2]=3'b011 (BEQZ/BNEZ/BLTZ/BGEZ).
  - Jump: op[4:2]=3'b001.
  - Everything else: non-branch.
- Table: 2^IDX_BITS entries × 2-bit counters.
  - Encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
  - Prediction bit = counter[1].
- pred_taken:
  - if_valid=0 → 0.
  - Jump → 1.
  - Conditional → table[if_pc[IDX_BITS:1]][1].
  - Other → 0.
  - Zero-cycle combinational read of registered table; if_pc[0] ignored.
- Update, on posedge when res_valid=1 and res_op is conditional only:
  - res_taken=1 → counter increments, saturating at 11.
  - res_taken=0 → counter decrements, saturating at 00.
  - Jumps and non-branches never write the table.
- Same-cycle read/write to the same index: pred_taken uses the pre-update value; no bypass. New value is visible the next cycle.
- Writes to two different indices never happen; only one resolve port exists.
- mispredict = res_valid & (res_taken != res_pred). Applies to every instruction class, so a wrongly carried res_pred on a jump or non-branch still flags. Same-cycle, no latency.
- Statistics:
  - branch_cnt +1 per resolved conditional.
  - mispred_cnt +1 per cycle with mispredict=1.
  - Both saturate at all-ones and never wrap.
- Reset, synchronous:
  - All table entries → 01 (weak NT).
  - branch_cnt=0, mispred_cnt=0.
  - Combinational outputs follow inputs during rst.
  - rst=1 overrides a coincident res_valid update, so the table ends at 01.
  - Reset mid-stream discards all history.
- res_valid=0: no state change; mispredict=0.

Decomposition:
- Shared core package:
  - Opcode-class constants OP_CLS_BR=3'b011 and OP_CLS_J=3'b001 (shared with the branch detector and decoder).
  - Counter encodings SNT/WNT/WT/ST.
- One natural sub-module: sat_counter2 (2-bit up/down saturating counter with inc/dec/en), instantiated per entry via generate.
- Stats counters are inline.

Test Plan:
- Reset then fetch BEQZ (if_op=5'b01100) at pc=0x0010 → pred_taken=0; branch_cnt=0, mispred_cnt=0.
- Resolve pc=0x0010 taken twice with res_pred=0 then 0 → mispredict=1 both cycles; entry 8 goes 01→10→11; next fetch at 0x0010 → pred_taken=1; mispred_cnt=2, branch_cnt=2.
- Aliasing: train pc=0x0010 to 11, then resolve pc=0x0030 (same index 8) not-taken ×3 → entry 00; fetch 0x0010 → pred_taken=0.
- Saturation and simultaneity:
  - Entry at 11, resolve taken ×5 → stays 11.
  - Fetch and resolve the same index in one cycle with 01→10 → pred_taken=0 that cycle, 1 the next.
- Jump: if_op=5'b00100 → pred_taken=1 regardless of table; resolve taken with res_pred=1 → mispredict=0, table and branch_cnt unchanged.
- Reset during update: rst=1 coincident with res_valid=1, taken, on a trained index → after edge entry=01, counters=0. Force mispred_cnt near 0xFFFF via 65535+ mispredicts (or a short-CNT_W build) → holds at all-ones.
